bp_cce_mshr_file: RTL and testbench
===================================

Name: bp_cce_mshr_file

Overview:
- Multi-entry MSHR file for the CCE, replacing the single-MSHR scheme so several LCE misses can be outstanding at once.
- Each entry tracks one request: requesting LCE, block address, way and size.
- Each entry runs a small lifecycle: allocate, issue to memory, await response, retire.
- Blocks allocation of a second request to a block already in flight.
- Sits between the CCE request decode and the memory command/response path.

Parameters:
- num_mshr_p, 4, number of entries (power of two, >=2)
- lce_id_width_p, 4, LCE id width
- lce_assoc_p, 8, LCE associativity; way field width = BSG_SAFE_CLOG2(lce_assoc_p)
- paddr_width_p, 40, physical address width
- block_width_p, 512, cache block bits; block offset = clog2(block_width_p/8)
- timeout_cycles_p, 1024, watchdog limit (optional feature only)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- alloc_v_i  in  1  new request valid
- alloc_lce_id_i  in  lce_id_width_p  requesting LCE
- alloc_paddr_i  in  paddr_width_p  request address
- alloc_way_id_i  in  clog2(assoc)  target way
- alloc_size_i  in  3  bp_bedrock_msg_size_e
- alloc_ready_and_o  out  1  entry free and no block conflict
- alloc_conflict_o  out  1  live entry already holds alloc block address
- alloc_id_o  out  clog2(num_mshr_p)  index that will be allocated
- issue_v_o  out  1  an entry awaits memory issue
- issue_id_o / issue_paddr_o / issue_size_o  out  idx/paddr/3  issuing entry fields
- issue_yumi_i  in  1  memory command accepted
- resp_v_i  in  1  memory response returned
- resp_id_i  in  clog2(num_mshr_p)  entry the response belongs to
- retire_v_o  out  1  an entry is complete
- retire_id_o / retire_lce_id_o / retire_paddr_o / retire_way_id_o  out  completing entry fields
- retire_yumi_i  in  1  consumer takes completed entry
- occupancy_o  out  clog2(num_mshr_p+1)  non-FREE entry count
- error_o  out  1  sticky watchdog error

Behaviour:
- Per-entry state: FREE -> ALLOC -> PENDING -> DONE -> FREE.
- Reset (async, immediate): all entries FREE; all fields zero.
  - Outputs 0: alloc_ready_and_o, issue_v_o, retire_v_o, occupancy_o, error_o.
  - alloc_conflict_o and alloc_id_o also reset to 0.
  - Reset mid-operation discards all entries; no responses are replayed.
- Block address = paddr with block-offset bits cleared.
- alloc_conflict_o: comb.; alloc_v_i & any non-FREE entry with equal block address.
- alloc_id_o: lowest-index FREE entry.
- alloc_ready_and_o = any FREE & ~alloc_conflict_o.
- Alloc fire = alloc_v_i & alloc_ready_and_o. Entry becomes ALLOC next cycle and captures all alloc fields.
- Issue:
  - issue_v_o set when any entry is ALLOC; lowest index wins.
  - Issue fields are that entry's captured fields.
  - issue_yumi_i moves the entry ALLOC -> PENDING.
  - issue_yumi_i with issue_v_o low is illegal and is ignored.
- Response: resp_v_i moves entry resp_id_i PENDING -> DONE. A response to a non-PENDING entry is ignored and changes no state.
- Retire:
  - retire_v_o set when any entry is DONE; lowest index wins.
  - retire_yumi_i moves the entry DONE -> FREE.
- Full/conflict timing: all decisions use registered state.
  - No same-cycle bypass: an entry retiring in cycle N is allocatable in cycle N+1.
  - A conflict against an entry retiring in cycle N still blocks allocation in cycle N.
- Simultaneous alloc, issue, resp and retire on different entries all take effect in the same cycle.
- An entry is never in two transitions in one cycle; the lifecycle guarantees this.
- occupancy_o = registered count of non-FREE entries. Updates each cycle by +alloc_fire -retire_fire; never wraps.
- Minimum latency: alloc in cycle 0 -> issue_v_o in cycle 1; resp in cycle N -> retire_v_o in cycle N+1.

Optional Feature:
- Macro BP_CCE_MSHR_FILE_TIMEOUT_EN.
- When defined:
  - Each entry has a counter of width clog2(timeout_cycles_p+1), cleared on entering PENDING and incremented while PENDING.
  - When any counter reaches timeout_cycles_p, error_o sets and stays set until reset.
  - The entry stays PENDING; no state is altered.
- When undefined: no counters are built; error_o is tied 0.

Test Plan:
- Alloc paddr 0x8000_0040, LCE 2, way 3 -> cycle 1: issue_v_o=1, issue_id_o=0, issue_paddr_o=0x8000_0040; yumi -> occupancy_o=1. resp_v_i id 0 -> next cycle retire_v_o=1 with lce_id 2, way 3; yumi -> occupancy_o=0.
- Entry 0 live at 0x1000 -> alloc 0x1038 (same 64B block) -> alloc_conflict_o=1, alloc_ready_and_o=0. Alloc 0x1040 -> accepted into id 1.
- Fill all 4 entries -> alloc_ready_and_o=0, occupancy_o=4. Retire id 2 in cycle N -> ready=1 in N+1 with alloc_id_o=2, not in N.
- Responses for ids 3 then 1 (out of order) -> retire order 1 then 3 when both DONE (lowest index). resp to FREE id 0 -> no state change.
- Assert reset_i mid-stream with 3 entries live -> all outputs 0 immediately, without waiting for a clock edge.
- With BP_CCE_MSHR_FILE_TIMEOUT_EN and timeout_cycles_p=16, hold entry PENDING for 16 cycles -> error_o=1, stays 1. Without the macro -> error_o=0.

Source files
------------

// File: rtl/bp_cce_mshr_file.sv
// ============================================================================
// Module      : bp_cce_mshr_file
// Description : Multi-entry MSHR file tracking outstanding LCE misses through
//               FREE -> ALLOC -> PENDING -> DONE -> FREE. Optional pending
//               watchdog enabled by BP_CCE_MSHR_FILE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_cce_mshr_file #(
  parameter int num_mshr_p       = 4,
  parameter int lce_id_width_p   = 4,
  parameter int lce_assoc_p      = 8,
  parameter int paddr_width_p    = 40,
  parameter int block_width_p    = 512,
  parameter int timeout_cycles_p = 1024
) (
  input  logic                                                clk_i,
  input  logic                                                reset_i,
  input  logic                                                alloc_v_i,
  input  logic [lce_id_width_p-1:0]                           alloc_lce_id_i,
  input  logic [paddr_width_p-1:0]                            alloc_paddr_i,
  input  logic [((lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1)-1:0] alloc_way_id_i,
  input  logic [2:0]                                          alloc_size_i,
  output logic                                                alloc_ready_and_o,
  output logic                                                alloc_conflict_o,
  output logic [$clog2(num_mshr_p)-1:0]                       alloc_id_o,
  output logic                                                issue_v_o,
  output logic [$clog2(num_mshr_p)-1:0]                       issue_id_o,
  output logic [paddr_width_p-1:0]                            issue_paddr_o,
  output logic [2:0]                                          issue_size_o,
  input  logic                                                issue_yumi_i,
  input  logic                                                resp_v_i,
  input  logic [$clog2(num_mshr_p)-1:0]                       resp_id_i,
  output logic                                                retire_v_o,
  output logic [$clog2(num_mshr_p)-1:0]                       retire_id_o,
  output logic [lce_id_width_p-1:0]                           retire_lce_id_o,
  output logic [paddr_width_p-1:0]                            retire_paddr_o,
  output logic [((lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1)-1:0] retire_way_id_o,
  input  logic                                                retire_yumi_i,
  output logic [$clog2(num_mshr_p+1)-1:0]                     occupancy_o,
  output logic                                                error_o
);

  localparam int IDX_W = $clog2(num_mshr_p);
  localparam int WAY_W = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;
  localparam int OCC_W = $clog2(num_mshr_p + 1);
  localparam int OFF_W = $clog2(block_width_p / 8);

  typedef enum logic [1:0] {
    E_FREE    = 2'd0,
    E_ALLOC   = 2'd1,
    E_PENDING = 2'd2,
    E_DONE    = 2'd3
  } entry_state_e;

  entry_state_e              state_q [num_mshr_p];
  entry_state_e              state_d [num_mshr_p];
  logic [lce_id_width_p-1:0] lce_q   [num_mshr_p];
  logic [lce_id_width_p-1:0] lce_d   [num_mshr_p];
  logic [paddr_width_p-1:0]  paddr_q [num_mshr_p];
  logic [paddr_width_p-1:0]  paddr_d [num_mshr_p];
  logic [WAY_W-1:0]          way_q   [num_mshr_p];
  logic [WAY_W-1:0]          way_d   [num_mshr_p];
  logic [2:0]                size_q  [num_mshr_p];
  logic [2:0]                size_d  [num_mshr_p];
  logic [OCC_W-1:0]          occ_q, occ_d;

  logic             any_free, conflict_hit, issue_found, retire_found;
  logic [IDX_W-1:0] free_idx, issue_idx, retire_idx;
  logic             alloc_fire, issue_fire, resp_fire, retire_fire;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    any_free     = 1'b0;
    conflict_hit = 1'b0;
    issue_found  = 1'b0;
    retire_found = 1'b0;
    free_idx     = '0;
    issue_idx    = '0;
    retire_idx   = '0;
    for (int i = num_mshr_p - 1; i >= 0; i--) begin
      if (state_q[i] == E_FREE) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end else if (paddr_q[i][paddr_width_p-1:OFF_W] == alloc_paddr_i[paddr_width_p-1:OFF_W]) begin
        conflict_hit = 1'b1;
      end
      if (state_q[i] == E_ALLOC) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (state_q[i] == E_DONE) begin
        retire_found = 1'b1;
        retire_idx   = IDX_W'(i);
      end
    end
  end

  assign alloc_conflict_o  = alloc_v_i & conflict_hit;
  assign alloc_ready_and_o = ~reset_i & any_free & ~alloc_conflict_o;
  assign alloc_id_o        = free_idx;

  assign issue_v_o     = issue_found;
  assign issue_id_o    = issue_idx;
  assign issue_paddr_o = paddr_q[issue_idx];
  assign issue_size_o  = size_q[issue_idx];

  assign retire_v_o      = retire_found;
  assign retire_id_o     = retire_idx;
  assign retire_lce_id_o = lce_q[retire_idx];
  assign retire_paddr_o  = paddr_q[retire_idx];
  assign retire_way_id_o = way_q[retire_idx];

  assign occupancy_o = occ_q;

  assign alloc_fire  = alloc_v_i & alloc_ready_and_o;
  assign issue_fire  = issue_v_o & issue_yumi_i;
  assign resp_fire   = resp_v_i & (state_q[resp_id_i] == E_PENDING);
  assign retire_fire = retire_v_o & retire_yumi_i;

  // Each fire targets an entry in a distinct state, so the updates never collide.
  always_comb begin
    state_d = state_q;
    lce_d   = lce_q;
    paddr_d = paddr_q;
    way_d   = way_q;
    size_d  = size_q;
    if (alloc_fire) begin
      state_d[free_idx] = E_ALLOC;
      lce_d[free_idx]   = alloc_lce_id_i;
      paddr_d[free_idx] = alloc_paddr_i;
      way_d[free_idx]   = alloc_way_id_i;
      size_d[free_idx]  = alloc_size_i;
    end
    if (issue_fire) begin
      state_d[issue_idx] = E_PENDING;
    end
    if (resp_fire) begin
      state_d[resp_id_i] = E_DONE;
    end
    if (retire_fire) begin
      state_d[retire_idx] = E_FREE;
    end
    occ_d = occ_q + OCC_W'(alloc_fire) - OCC_W'(retire_fire);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_mshr_p; i++) begin
        state_q[i] <= E_FREE;
        lce_q[i]   <= '0;
        paddr_q[i] <= '0;
        way_q[i]   <= '0;
        size_q[i]  <= '0;
      end
      occ_q <= '0;
    end else begin
      state_q <= state_d;
      lce_q   <= lce_d;
      paddr_q <= paddr_d;
      way_q   <= way_d;
      size_q  <= size_d;
      occ_q   <= occ_d;
    end
  end

`ifdef BP_CCE_MSHR_FILE_TIMEOUT_EN
  localparam int CNT_W = $clog2(timeout_cycles_p + 1);

  logic [CNT_W-1:0] cnt_q [num_mshr_p];
  logic [CNT_W-1:0] cnt_d [num_mshr_p];
  logic             err_q, err_d;

  // Counters saturate at the limit; the error flag is raised on the edge the limit is reached.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    for (int i = 0; i < num_mshr_p; i++) begin
      if (issue_fire && (issue_idx == IDX_W'(i))) begin
        cnt_d[i] = '0;
      end else if ((state_q[i] == E_PENDING) && (cnt_q[i] != CNT_W'(timeout_cycles_p))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        if (cnt_d[i] == CNT_W'(timeout_cycles_p)) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_mshr_p; i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign error_o = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^timeout_cycles_p;
  assign error_o            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_cce_mshr_file.sv
// ============================================================================
// Module      : tb_bp_cce_mshr_file
// Description : Self-checking bench for bp_cce_mshr_file with directed
//               scenarios and a randomized run against a lifecycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_cce_mshr_file;

  localparam int N     = 4;
  localparam int LCE_W = 4;
  localparam int ASSOC = 8;
  localparam int PA_W  = 40;
  localparam int BLK   = 512;
  localparam int T     = 16;
  localparam int IDX_W = 2;
  localparam int WAY_W = 3;
  localparam int OCC_W = 3;
  localparam int OFF   = 6;

  localparam int S_FREE = 0;
  localparam int S_ALLOC = 1;
  localparam int S_PEND = 2;
  localparam int S_DONE = 3;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             alloc_v_i;
  logic [LCE_W-1:0] alloc_lce_id_i;
  logic [PA_W-1:0]  alloc_paddr_i;
  logic [WAY_W-1:0] alloc_way_id_i;
  logic [2:0]       alloc_size_i;
  logic             alloc_ready_and_o;
  logic             alloc_conflict_o;
  logic [IDX_W-1:0] alloc_id_o;
  logic             issue_v_o;
  logic [IDX_W-1:0] issue_id_o;
  logic [PA_W-1:0]  issue_paddr_o;
  logic [2:0]       issue_size_o;
  logic             issue_yumi_i;
  logic             resp_v_i;
  logic [IDX_W-1:0] resp_id_i;
  logic             retire_v_o;
  logic [IDX_W-1:0] retire_id_o;
  logic [LCE_W-1:0] retire_lce_id_o;
  logic [PA_W-1:0]  retire_paddr_o;
  logic [WAY_W-1:0] retire_way_id_o;
  logic             retire_yumi_i;
  logic [OCC_W-1:0] occupancy_o;
  logic             error_o;

  always #5 clk_i = ~clk_i;

  bp_cce_mshr_file #(
    .num_mshr_p      (N),
    .lce_id_width_p  (LCE_W),
    .lce_assoc_p     (ASSOC),
    .paddr_width_p   (PA_W),
    .block_width_p   (BLK),
    .timeout_cycles_p(T)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .alloc_v_i        (alloc_v_i),
    .alloc_lce_id_i   (alloc_lce_id_i),
    .alloc_paddr_i    (alloc_paddr_i),
    .alloc_way_id_i   (alloc_way_id_i),
    .alloc_size_i     (alloc_size_i),
    .alloc_ready_and_o(alloc_ready_and_o),
    .alloc_conflict_o (alloc_conflict_o),
    .alloc_id_o       (alloc_id_o),
    .issue_v_o        (issue_v_o),
    .issue_id_o       (issue_id_o),
    .issue_paddr_o    (issue_paddr_o),
    .issue_size_o     (issue_size_o),
    .issue_yumi_i     (issue_yumi_i),
    .resp_v_i         (resp_v_i),
    .resp_id_i        (resp_id_i),
    .retire_v_o       (retire_v_o),
    .retire_id_o      (retire_id_o),
    .retire_lce_id_o  (retire_lce_id_o),
    .retire_paddr_o   (retire_paddr_o),
    .retire_way_id_o  (retire_way_id_o),
    .retire_yumi_i    (retire_yumi_i),
    .occupancy_o      (occupancy_o),
    .error_o          (error_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one lifecycle stage per entry plus its captured request.
  int               m_st    [N];
  logic [LCE_W-1:0] m_lce   [N];
  logic [PA_W-1:0]  m_paddr [N];
  logic [WAY_W-1:0] m_way   [N];
  logic [2:0]       m_size  [N];
  int               m_cnt   [N];
  bit               m_err;

  bit               e_ready, e_conflict, e_issue_v, e_retire_v, e_err;
  logic [IDX_W-1:0] e_alloc_id, e_issue_id, e_retire_id;
  logic [OCC_W-1:0] e_occ;

  task automatic set_idle();
    alloc_v_i      = 1'b0;
    alloc_lce_id_i = '0;
    alloc_paddr_i  = '0;
    alloc_way_id_i = '0;
    alloc_size_i   = '0;
    issue_yumi_i   = 1'b0;
    resp_v_i       = 1'b0;
    resp_id_i      = '0;
    retire_yumi_i  = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i]    = S_FREE;
      m_lce[i]   = '0;
      m_paddr[i] = '0;
      m_way[i]   = '0;
      m_size[i]  = '0;
      m_cnt[i]   = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_eval();
    bit found_free;
    found_free = 1'b0;
    e_conflict = 1'b0;
    e_issue_v  = 1'b0;
    e_retire_v = 1'b0;
    e_alloc_id = '0;
    e_issue_id = '0;
    e_retire_id = '0;
    e_occ      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_st[i] == S_FREE) begin
        found_free = 1'b1;
        e_alloc_id = IDX_W'(i);
      end else begin
        e_occ = e_occ + 1'b1;
        if (alloc_v_i && ((m_paddr[i] >> OFF) == (alloc_paddr_i >> OFF))) e_conflict = 1'b1;
      end
      if (m_st[i] == S_ALLOC) begin
        e_issue_v  = 1'b1;
        e_issue_id = IDX_W'(i);
      end
      if (m_st[i] == S_DONE) begin
        e_retire_v  = 1'b1;
        e_retire_id = IDX_W'(i);
      end
    end
    e_ready = found_free && !e_conflict && !reset_i;
    e_err   = m_err;
  endtask

  // Advance the model by one clock with the inputs currently driven, then clock the DUT.
  task automatic tick();
    model_eval();
`ifdef BP_CCE_MSHR_FILE_TIMEOUT_EN
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == S_PEND) begin
        m_cnt[i]++;
        if (m_cnt[i] >= T) m_err = 1'b1;
      end
    end
`endif
    if (resp_v_i && (m_st[resp_id_i] == S_PEND)) m_st[resp_id_i] = S_DONE;
    if (issue_yumi_i && e_issue_v) begin
      m_st[e_issue_id]  = S_PEND;
      m_cnt[e_issue_id] = 0;
    end
    if (retire_yumi_i && e_retire_v) m_st[e_retire_id] = S_FREE;
    if (alloc_v_i && e_ready) begin
      m_st[e_alloc_id]    = S_ALLOC;
      m_lce[e_alloc_id]   = alloc_lce_id_i;
      m_paddr[e_alloc_id] = alloc_paddr_i;
      m_way[e_alloc_id]   = alloc_way_id_i;
      m_size[e_alloc_id]  = alloc_size_i;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    set_idle();
    model_eval();
    while (e_occ != 0 && guard < 64) begin
      set_idle();
      issue_yumi_i  = e_issue_v;
      retire_yumi_i = e_retire_v;
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == S_PEND) begin
          resp_v_i  = 1'b1;
          resp_id_i = IDX_W'(i);
        end
      end
      tick();
      model_eval();
      guard++;
    end
    set_idle();
    #1;
    checks++;
    if (occupancy_o !== 3'd0) begin
      failures++;
      $display("FAIL drain_empty occupancy=%0d expected 0 after %0d cycles", occupancy_o, guard);
    end
  endtask

  task automatic alloc_entry(input logic [PA_W-1:0] pa, input int lce, input int way);
    set_idle();
    alloc_v_i      = 1'b1;
    alloc_paddr_i  = pa;
    alloc_lce_id_i = LCE_W'(lce);
    alloc_way_id_i = WAY_W'(way);
    alloc_size_i   = 3'd6;
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    reset_i   = 1'b1;
    alloc_v_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({alloc_ready_and_o, alloc_conflict_o, alloc_id_o, issue_v_o, retire_v_o, occupancy_o, error_o} !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs ready=%0b conf=%0b id=%0d issue_v=%0b retire_v=%0b occ=%0d err=%0b expected all 0",
               alloc_ready_and_o, alloc_conflict_o, alloc_id_o, issue_v_o, retire_v_o, occupancy_o, error_o);
    end
    set_idle();
    reset_i = 1'b0;
    #1;
    checks++;
    if (alloc_ready_and_o !== 1'b1 || alloc_id_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_release ready=%0b id=%0d expected ready=1 id=0", alloc_ready_and_o, alloc_id_o);
    end
  endtask

  task automatic test_basic();
    set_idle();
    alloc_v_i      = 1'b1;
    alloc_paddr_i  = 40'h80_0000_40;
    alloc_paddr_i  = 40'h00_8000_0040;
    alloc_lce_id_i = 4'd2;
    alloc_way_id_i = 3'd3;
    alloc_size_i   = 3'd6;
    #1;
    checks++;
    if (alloc_ready_and_o !== 1'b1 || alloc_id_o !== 2'd0 || alloc_conflict_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_alloc ready=%0b id=%0d conf=%0b expected 1/0/0", alloc_ready_and_o, alloc_id_o, alloc_conflict_o);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (issue_v_o !== 1'b1 || issue_id_o !== 2'd0 || issue_paddr_o !== 40'h00_8000_0040 || issue_size_o !== 3'd6) begin
      failures++;
      $display("FAIL basic_issue v=%0b id=%0d paddr=%h size=%0d expected 1/0/0080000040/6",
               issue_v_o, issue_id_o, issue_paddr_o, issue_size_o);
    end
    issue_yumi_i = 1'b1;
    tick();
    set_idle();
    #1;
    checks++;
    if (occupancy_o !== 3'd1 || issue_v_o !== 1'b0 || retire_v_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_pending occ=%0d issue_v=%0b retire_v=%0b expected 1/0/0", occupancy_o, issue_v_o, retire_v_o);
    end
    resp_v_i  = 1'b1;
    resp_id_i = 2'd0;
    tick();
    set_idle();
    #1;
    checks++;
    if (retire_v_o !== 1'b1 || retire_id_o !== 2'd0 || retire_lce_id_o !== 4'd2 || retire_way_id_o !== 3'd3 ||
        retire_paddr_o !== 40'h00_8000_0040) begin
      failures++;
      $display("FAIL basic_retire v=%0b id=%0d lce=%0d way=%0d paddr=%h expected 1/0/2/3/0080000040",
               retire_v_o, retire_id_o, retire_lce_id_o, retire_way_id_o, retire_paddr_o);
    end
    retire_yumi_i = 1'b1;
    tick();
    set_idle();
    #1;
    checks++;
    if (occupancy_o !== 3'd0 || retire_v_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_freed occ=%0d retire_v=%0b expected 0/0", occupancy_o, retire_v_o);
    end
  endtask

  task automatic test_conflict();
    alloc_entry(40'h1000, 1, 0);
    alloc_v_i     = 1'b1;
    alloc_paddr_i = 40'h1038;
    #1;
    checks++;
    if (alloc_conflict_o !== 1'b1 || alloc_ready_and_o !== 1'b0) begin
      failures++;
      $display("FAIL conflict_same_block conf=%0b ready=%0b expected 1/0", alloc_conflict_o, alloc_ready_and_o);
    end
    tick();
    alloc_paddr_i = 40'h1040;
    #1;
    checks++;
    if (alloc_conflict_o !== 1'b0 || alloc_ready_and_o !== 1'b1 || alloc_id_o !== 2'd1) begin
      failures++;
      $display("FAIL conflict_next_block conf=%0b ready=%0b id=%0d expected 0/1/1", alloc_conflict_o, alloc_ready_and_o, alloc_id_o);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (occupancy_o !== 3'd2) begin
      failures++;
      $display("FAIL conflict_occ occ=%0d expected 2", occupancy_o);
    end
    drain();
  endtask

  task automatic test_full();
    for (int i = 0; i < N; i++) alloc_entry(40'h2000 + 40'(i * 64), i, i);
    alloc_v_i     = 1'b1;
    alloc_paddr_i = 40'h3000;
    #1;
    checks++;
    if (alloc_ready_and_o !== 1'b0 || occupancy_o !== 3'd4 || alloc_conflict_o !== 1'b0) begin
      failures++;
      $display("FAIL full_blocked ready=%0b occ=%0d conf=%0b expected 0/4/0", alloc_ready_and_o, occupancy_o, alloc_conflict_o);
    end
    set_idle();
    for (int i = 0; i < N; i++) begin
      issue_yumi_i = 1'b1;
      tick();
    end
    set_idle();
    resp_v_i  = 1'b1;
    resp_id_i = 2'd2;
    tick();
    set_idle();
    retire_yumi_i = 1'b1;
    alloc_v_i     = 1'b1;
    alloc_paddr_i = 40'h3000;
    #1;
    checks++;
    if (retire_v_o !== 1'b1 || retire_id_o !== 2'd2 || alloc_ready_and_o !== 1'b0) begin
      failures++;
      $display("FAIL full_retire_cycle retire_v=%0b id=%0d ready=%0b expected 1/2/0", retire_v_o, retire_id_o, alloc_ready_and_o);
    end
    tick();
    retire_yumi_i = 1'b0;
    #1;
    checks++;
    if (alloc_ready_and_o !== 1'b1 || alloc_id_o !== 2'd2 || occupancy_o !== 3'd3) begin
      failures++;
      $display("FAIL full_next_cycle ready=%0b id=%0d occ=%0d expected 1/2/3", alloc_ready_and_o, alloc_id_o, occupancy_o);
    end
    drain();
  endtask

  task automatic test_out_of_order();
    set_idle();
    resp_v_i  = 1'b1;
    resp_id_i = 2'd0;
    tick();
    set_idle();
    #1;
    checks++;
    if (retire_v_o !== 1'b0 || occupancy_o !== 3'd0 || issue_v_o !== 1'b0) begin
      failures++;
      $display("FAIL resp_to_free retire_v=%0b occ=%0d issue_v=%0b expected 0/0/0", retire_v_o, occupancy_o, issue_v_o);
    end
    for (int i = 0; i < N; i++) alloc_entry(40'h4000 + 40'(i * 64), i + 4, i);
    for (int i = 0; i < N; i++) begin
      issue_yumi_i = 1'b1;
      tick();
    end
    set_idle();
    resp_v_i  = 1'b1;
    resp_id_i = 2'd3;
    tick();
    resp_id_i = 2'd1;
    tick();
    set_idle();
    #1;
    checks++;
    if (retire_v_o !== 1'b1 || retire_id_o !== 2'd1 || retire_lce_id_o !== 4'd5) begin
      failures++;
      $display("FAIL ooo_first v=%0b id=%0d lce=%0d expected 1/1/5", retire_v_o, retire_id_o, retire_lce_id_o);
    end
    retire_yumi_i = 1'b1;
    tick();
    #1;
    checks++;
    if (retire_v_o !== 1'b1 || retire_id_o !== 2'd3 || retire_paddr_o !== 40'h40c0) begin
      failures++;
      $display("FAIL ooo_second v=%0b id=%0d paddr=%h expected 1/3/40c0", retire_v_o, retire_id_o, retire_paddr_o);
    end
    tick();
    set_idle();
    resp_v_i  = 1'b1;
    resp_id_i = 2'd1;
    tick();
    set_idle();
    #1;
    checks++;
    if (retire_v_o !== 1'b0 || occupancy_o !== 3'd2) begin
      failures++;
      $display("FAIL ooo_stale_resp retire_v=%0b occ=%0d expected 0/2", retire_v_o, occupancy_o);
    end
    drain();
  endtask

  task automatic test_timeout();
    alloc_entry(40'h5000, 3, 1);
    issue_yumi_i = 1'b1;
    tick();
    set_idle();
`ifdef BP_CCE_MSHR_FILE_TIMEOUT_EN
    repeat (T - 1) tick();
    #1;
    checks++;
    if (error_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early err=%0b expected 0", error_o);
    end
    tick();
    #1;
    checks++;
    if (error_o !== 1'b1 || occupancy_o !== 3'd1) begin
      failures++;
      $display("FAIL timeout_hit err=%0b occ=%0d expected 1/1", error_o, occupancy_o);
    end
    drain();
    checks++;
    if (error_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky err=%0b expected 1", error_o);
    end
`else
    repeat (T + 4) tick();
    #1;
    checks++;
    if (error_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_disabled err=%0b expected 0", error_o);
    end
    drain();
`endif
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) alloc_entry(40'h6000 + 40'(i * 64), i, i);
    issue_yumi_i = 1'b1;
    tick();
    set_idle();
    alloc_v_i     = 1'b1;
    alloc_paddr_i = 40'h6040;
    #1;
    checks++;
    if (alloc_conflict_o !== 1'b1 || occupancy_o !== 3'd3 || issue_v_o !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre conf=%0b occ=%0d issue_v=%0b expected 1/3/1", alloc_conflict_o, occupancy_o, issue_v_o);
    end
    reset_i = 1'b1;
    #1;
    checks++;
    if ({alloc_ready_and_o, alloc_conflict_o, alloc_id_o, issue_v_o, retire_v_o, occupancy_o, error_o} !== 9'd0) begin
      failures++;
      $display("FAIL areset_immediate ready=%0b conf=%0b id=%0d issue_v=%0b retire_v=%0b occ=%0d err=%0b expected all 0",
               alloc_ready_and_o, alloc_conflict_o, alloc_id_o, issue_v_o, retire_v_o, occupancy_o, error_o);
    end
    set_idle();
    model_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    #1;
    checks++;
    if (alloc_ready_and_o !== 1'b1 || occupancy_o !== 3'd0 || issue_v_o !== 1'b0) begin
      failures++;
      $display("FAIL areset_release ready=%0b occ=%0d issue_v=%0b expected 1/0/0", alloc_ready_and_o, occupancy_o, issue_v_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_idle();
      alloc_v_i      = 1'($urandom_range(0, 1));
      alloc_paddr_i  = 40'h1_0000 + 40'($urandom_range(0, 5) * 64) + 40'($urandom_range(0, 63));
      alloc_lce_id_i = LCE_W'($urandom);
      alloc_way_id_i = WAY_W'($urandom);
      alloc_size_i   = 3'($urandom);
      issue_yumi_i   = ($urandom_range(0, 3) != 0);
      resp_v_i       = 1'($urandom_range(0, 1));
      resp_id_i      = IDX_W'($urandom);
      retire_yumi_i  = ($urandom_range(0, 2) != 0);
      #1;
      model_eval();
      checks++;
      if (alloc_ready_and_o !== e_ready || alloc_conflict_o !== e_conflict || alloc_id_o !== e_alloc_id) begin
        failures++;
        $display("FAIL rand_alloc cyc=%0d got ready=%0b conf=%0b id=%0d want %0b/%0b/%0d",
                 c, alloc_ready_and_o, alloc_conflict_o, alloc_id_o, e_ready, e_conflict, e_alloc_id);
      end
      checks++;
      if (issue_v_o !== e_issue_v ||
          (e_issue_v && (issue_id_o !== e_issue_id || issue_paddr_o !== m_paddr[e_issue_id] ||
                         issue_size_o !== m_size[e_issue_id]))) begin
        failures++;
        $display("FAIL rand_issue cyc=%0d got v=%0b id=%0d paddr=%h want v=%0b id=%0d paddr=%h",
                 c, issue_v_o, issue_id_o, issue_paddr_o, e_issue_v, e_issue_id, m_paddr[e_issue_id]);
      end
      checks++;
      if (retire_v_o !== e_retire_v ||
          (e_retire_v && (retire_id_o !== e_retire_id || retire_lce_id_o !== m_lce[e_retire_id] ||
                          retire_paddr_o !== m_paddr[e_retire_id] || retire_way_id_o !== m_way[e_retire_id]))) begin
        failures++;
        $display("FAIL rand_retire cyc=%0d got v=%0b id=%0d lce=%0d want v=%0b id=%0d lce=%0d",
                 c, retire_v_o, retire_id_o, retire_lce_id_o, e_retire_v, e_retire_id, m_lce[e_retire_id]);
      end
      checks++;
      if (occupancy_o !== e_occ || error_o !== e_err) begin
        failures++;
        $display("FAIL rand_occ cyc=%0d got occ=%0d err=%0b want occ=%0d err=%0b", c, occupancy_o, error_o, e_occ, e_err);
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_conflict();
    test_full();
    test_out_of_order();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
